// File: rtl/deserializer_buf.sv
// deserializer_buf
//   Collects N_SAMPLES words of BIT_WIDTH bits from a valid/ready input stream
//   and presents them as one packed batch on a valid/ready output. Word k of a
//   batch (k = 0 first received) sits at send_msg[k*BIT_WIDTH +: BIT_WIDTH].
//   The block is double-buffered: a fill buffer collects the next batch while
//   the output register holds the current one.
//
// Ports
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high reset
//   recv_msg : incoming word
//   recv_val : recv_msg valid
//   recv_rdy : block accepts a word this cycle
//   send_msg : assembled batch
//   send_val : send_msg valid
//   send_rdy : consumer accepts send_msg
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting words into the fill buffer
// HOLD  | fill buffer complete, output register still occupied
module deserializer_buf #(
  parameter int BIT_WIDTH = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int CW = ($clog2(N_SAMPLES) > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                     state;
  logic [CW-1:0]                  cnt;
  logic [BIT_WIDTH-1:0]           fill_mem [N_SAMPLES];
  logic [N_SAMPLES*BIT_WIDTH-1:0] fill_flat;
  logic [N_SAMPLES*BIT_WIDTH-1:0] batch_done;
  logic                           recv_hs;
  logic                           send_hs;

  always_comb begin
    fill_flat = '0;
    for (int k = 0; k < N_SAMPLES; k++) begin
      fill_flat[k*BIT_WIDTH +: BIT_WIDTH] = fill_mem[k];
    end
  end

  // The final word bypasses the fill buffer so the batch can move straight
  // to the output register in the same cycle it completes.
  assign batch_done = {recv_msg, fill_flat[(N_SAMPLES-1)*BIT_WIDTH-1:0]};

  assign recv_rdy = (state == FILL) && !reset;
  assign recv_hs  = recv_val && recv_rdy;
  assign send_hs  = send_val && send_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      cnt      <= '0;
      send_msg <= '0;
      send_val <= 1'b0;
      for (int k = 0; k < N_SAMPLES; k++) begin
        fill_mem[k] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          // Output drained with nothing new behind it; overridden below
          // when a batch completes in the same cycle.
          if (send_hs) begin
            send_val <= 1'b0;
          end
          if (recv_hs) begin
            if (cnt != CNT_LAST) begin
              fill_mem[cnt] <= recv_msg;
              cnt           <= cnt + CW'(1);
            end else begin
              cnt <= '0;
              if (!send_val || send_rdy) begin
                send_msg <= batch_done;
                send_val <= 1'b1;
              end else begin
                fill_mem[cnt] <= recv_msg;
                state         <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (send_rdy) begin
            send_msg <= fill_flat;
            send_val <= 1'b1;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_buf.sv
// tb_deserializer_buf
//   Directed scenarios with literal expectations plus a randomized phase,
//   all checked every cycle against a queue-based model of batch assembly.
module tb_deserializer_buf;

  localparam int BW = 8;
  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [BW-1:0]     recv_msg = '0;
  logic              recv_val = 1'b0;
  logic              recv_rdy;
  logic [NS*BW-1:0]  send_msg;
  logic              send_val;
  logic              send_rdy = 1'b0;

  int errors = 0;
  int checks = 0;

  deserializer_buf #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  always #5 clk = ~clk;

  // Model: words gathered in a queue; a completed batch either goes to the
  // output slot or waits as "pending" until the consumer takes the slot.
  logic [BW-1:0]    m_q[$];
  logic             m_pending = 1'b0;
  logic [NS*BW-1:0] m_pend_msg = '0;
  logic             m_val = 1'b0;
  logic [NS*BW-1:0] m_msg = '0;

  always @(posedge clk or posedge reset) begin
    logic loaded;
    logic fire;
    logic [NS*BW-1:0] b;
    if (reset) begin
      m_q.delete();
      m_pending = 1'b0;
      m_val = 1'b0;
      m_msg = '0;
    end else begin
      loaded = 1'b0;
      fire = m_val && send_rdy;
      if (m_pending) begin
        if (send_rdy) begin
          m_msg = m_pend_msg;
          m_val = 1'b1;
          m_pending = 1'b0;
          loaded = 1'b1;
        end
      end else if (recv_val) begin
        m_q.push_back(recv_msg);
        if (m_q.size() == NS) begin
          b = '0;
          for (int k = 0; k < NS; k++) b[k*BW +: BW] = m_q[k];
          m_q.delete();
          if (!m_val || send_rdy) begin
            m_msg = b;
            m_val = 1'b1;
            loaded = 1'b1;
          end else begin
            m_pend_msg = b;
            m_pending = 1'b1;
          end
        end
      end
      if (fire && !loaded) m_val = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("rst_recv_rdy", 64'(recv_rdy), 64'(0));
      check("rst_send_val", 64'(send_val), 64'(0));
      check("rst_send_msg", 64'(send_msg), 64'(0));
    end else begin
      check("model_recv_rdy", 64'(recv_rdy), 64'(!m_pending));
      check("model_send_val", 64'(send_val), 64'(m_val));
      if (m_val) check("model_send_msg", 64'(send_msg), 64'(m_msg));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    recv_val = 1'b0;
    send_rdy = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("post_rst_recv_rdy", 64'(recv_rdy), 64'(1));
  endtask

  task automatic drive_word(input logic [BW-1:0] w);
    recv_val = 1'b1;
    recv_msg = w;
    step();
  endtask

  logic [NS*BW-1:0] got[$];
  logic [BW-1:0]    gap_words[NS];

  initial begin
    do_reset();

    // basic
    send_rdy = 1'b1;
    drive_word(8'h11);
    drive_word(8'h22);
    drive_word(8'h33);
    drive_word(8'h44);
    check("basic_val", 64'(send_val), 64'(1));
    check("basic_msg", 64'(send_msg), 64'h44332211);
    recv_val = 1'b0;
    step();
    check("basic_val_clear", 64'(send_val), 64'(0));

    // backpressure
    do_reset();
    send_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) drive_word(BW'(i));
    recv_val = 1'b0;
    check("bp_msg1", 64'(send_msg), 64'h04030201);
    check("bp_val1", 64'(send_val), 64'(1));
    check("bp_rdy_hold", 64'(recv_rdy), 64'(0));
    step();
    check("bp_msg1_stable", 64'(send_msg), 64'h04030201);
    send_rdy = 1'b1;
    step();
    send_rdy = 1'b0;
    check("bp_msg2", 64'(send_msg), 64'h08070605);
    check("bp_val2", 64'(send_val), 64'(1));
    check("bp_rdy_back", 64'(recv_rdy), 64'(1));

    // simultaneous final word + output handshake
    do_reset();
    send_rdy = 1'b0;
    drive_word(8'hB1);
    drive_word(8'hB2);
    drive_word(8'hB3);
    drive_word(8'hB4);
    drive_word(8'hC1);
    drive_word(8'hC2);
    drive_word(8'hC3);
    check("sim_rdy_before", 64'(recv_rdy), 64'(1));
    check("sim_msg_b1", 64'(send_msg), 64'hB4B3B2B1);
    send_rdy = 1'b1;
    drive_word(8'hC4);
    recv_val = 1'b0;
    check("sim_rdy_after", 64'(recv_rdy), 64'(1));
    check("sim_val", 64'(send_val), 64'(1));
    check("sim_msg_b2", 64'(send_msg), 64'hC4C3C2C1);
    step();
    check("sim_val_clear", 64'(send_val), 64'(0));

    // streaming
    do_reset();
    send_rdy = 1'b1;
    got.delete();
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        check("stream_rdy", 64'(recv_rdy), 64'(1));
        if (send_val) got.push_back(send_msg);
      end
      if (i < 12) begin
        recv_val = 1'b1;
        recv_msg = BW'(i);
      end else begin
        recv_val = 1'b0;
      end
      if (i < 12) step();
    end
    check("stream_count", 64'(got.size()), 64'(3));
    if (got.size() == 3) begin
      check("stream_b0", 64'(got[0]), 64'h03020100);
      check("stream_b1", 64'(got[1]), 64'h07060504);
      check("stream_b2", 64'(got[2]), 64'h0B0A0908);
    end

    // reset mid-operation
    do_reset();
    send_rdy = 1'b1;
    drive_word(8'h55);
    drive_word(8'h66);
    recv_val = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_val", 64'(send_val), 64'(0));
    check("midrst_rdy", 64'(recv_rdy), 64'(0));
    step();
    reset = 1'b0;
    step();
    check("midrst_no_out", 64'(send_val), 64'(0));
    check("midrst_rdy_back", 64'(recv_rdy), 64'(1));
    drive_word(8'hA1);
    drive_word(8'hA2);
    drive_word(8'hA3);
    drive_word(8'hA4);
    recv_val = 1'b0;
    check("midrst_msg", 64'(send_msg), 64'hA4A3A2A1);
    check("midrst_val2", 64'(send_val), 64'(1));

    // recv gaps: same batch as gapless despite random idle cycles
    do_reset();
    send_rdy = 1'b1;
    gap_words[0] = 8'h5A;
    gap_words[1] = 8'h6B;
    gap_words[2] = 8'h7C;
    gap_words[3] = 8'h8D;
    for (int k = 0; k < NS; k++) begin
      int gaps;
      gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) begin
        recv_val = 1'b0;
        recv_msg = BW'($urandom);
        step();
      end
      drive_word(gap_words[k]);
    end
    recv_val = 1'b0;
    check("gap_val", 64'(send_val), 64'(1));
    check("gap_msg", 64'(send_msg), 64'h8D7C6B5A);
    step();

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      recv_val = ($urandom_range(0, 3) != 0);
      recv_msg = BW'($urandom);
      send_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
